// File: rtl/div8_if.sv
// Handshake/result bundle for the div8 sequential divider, with the FSM state exposed for checkers.
// start is a single-cycle command (no ready): it is accepted on any edge where it is high; done is a level that holds the result valid until the next start.
interface div8_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [1:0]       state;

    modport master (
        output start, A, B,
        input  quotient, remainder, busy, done, div_by_zero, state
    );

    modport slave (
        input  start, A, B,
        output quotient, remainder, busy, done, div_by_zero, state
    );
endinterface

// File: rtl/div8.sv
// Restoring shift/subtract divider producing one quotient bit per clock.
// Optional DIV8_SIGNED_EN: two's-complement operands, magnitude core plus sign fix-up on the done edge.
module div8 #(
    parameter int WIDTH = 8
) (
    input  logic  clk,
    input  logic  rst,
    div8_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rmd;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    logic [WIDTH:0]   w_shift_rem;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_dvd_nxt;
    logic             w_last;
    logic             w_zero_dsr;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic [WIDTH-1:0] w_dbz_rem;

    // The shifted-out MSB alone guarantees rem >= divisor, so the subtraction result always fits WIDTH bits.
    assign w_shift_rem = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge        = w_shift_rem[WIDTH] | (w_shift_rem[WIDTH-1:0] >= r_dsr);
    assign w_rem_nxt   = w_ge ? (w_shift_rem[WIDTH-1:0] - r_dsr) : w_shift_rem[WIDTH-1:0];
    assign w_dvd_nxt   = {r_dvd[WIDTH-2:0], w_ge};
    assign w_last      = (r_cnt == CW'(WIDTH - 1));
    assign w_zero_dsr  = (r_dsr == '0);

`ifdef DIV8_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    assign w_a_mag   = bus.A[WIDTH-1] ? (~bus.A + 1'b1) : bus.A;
    assign w_b_mag   = bus.B[WIDTH-1] ? (~bus.B + 1'b1) : bus.B;
    assign w_q_fix   = r_neg_q ? (~w_dvd_nxt + 1'b1) : w_dvd_nxt;
    assign w_r_fix   = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
    // Re-negating the stored magnitude recovers the original A, including the most-negative value.
    assign w_dbz_rem = r_neg_r ? (~r_dvd + 1'b1) : r_dvd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (bus.start) begin
            r_neg_q <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            r_neg_r <= bus.A[WIDTH-1];
        end
    end
`else
    assign w_a_mag   = bus.A;
    assign w_b_mag   = bus.B;
    assign w_q_fix   = w_dvd_nxt;
    assign w_r_fix   = w_rem_nxt;
    assign w_dbz_rem = r_dvd;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (bus.start) begin
            w_next_state = S_CALC;
        end else begin
            case (r_state)
                S_CALC:  if (w_zero_dsr || w_last) w_next_state = S_DONE;
                default: w_next_state = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd  <= '0;
            r_dsr  <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_quo  <= '0;
            r_rmd  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
        end else if (bus.start) begin
            r_dvd  <= w_a_mag;
            r_dsr  <= w_b_mag;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
        end else if (r_state == S_CALC) begin
            if (w_zero_dsr) begin
                r_quo  <= '1;
                r_rmd  <= w_dbz_rem;
                r_dbz  <= 1'b1;
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end else begin
                r_rem <= w_rem_nxt;
                r_dvd <= w_dvd_nxt;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_quo  <= w_q_fix;
                    r_rmd  <= w_r_fix;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign bus.quotient    = r_quo;
    assign bus.remainder   = r_rmd;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.state       = r_state;
endmodule

// File: tb/tb_div8.sv
// Directed self-checking bench for div8: reset, latency, zero divisor, restart, held start, edge vectors.
// Build with DIV8_SIGNED_EN to exercise the signed vectors instead of the unsigned-only ones.
module tb_div8;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   lat;

    div8_if #(.WIDTH(8)) bus ();

    div8 #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start edge is the posedge between the two negedges; returns at the negedge after it.
    task automatic pulse_start(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = 8'($urandom_range(0, 255));
        bus.B     = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_done(output int l);
        l = 99;
        for (int i = 1; i <= 20; i++) begin
            if (l == 99) begin
                @(negedge clk);
                if (bus.done === 1'b1) l = i;
            end
        end
    endtask

    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er,
                           input logic edbz, input int elat);
        int l;
        pulse_start(a, b);
        chk({tag, ".busy"}, bus.busy, 1);
        chk({tag, ".done_low"}, bus.done, 0);
        wait_done(l);
        chk({tag, ".latency"}, l, elat);
        chk({tag, ".quotient"}, bus.quotient, eq);
        chk({tag, ".remainder"}, bus.remainder, er);
        chk({tag, ".dbz"}, bus.div_by_zero, edbz);
        chk({tag, ".busy_end"}, bus.busy, 0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;

        @(negedge clk);
        chk("reset.quotient", bus.quotient, 0);
        chk("reset.remainder", bus.remainder, 0);
        chk("reset.done", bus.done, 0);
        chk("reset.busy", bus.busy, 0);
        chk("reset.state", bus.state, 0);
        rst = 1'b0;

`ifndef DIV8_SIGNED_EN
        run_div("u200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 8);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.A = 8'($urandom_range(0, 255));
            bus.B = 8'($urandom_range(0, 255));
            chk("hold.done", bus.done, 1);
        end
        chk("hold.quotient", bus.quotient, 28);
        chk("hold.remainder", bus.remainder, 4);
        chk("hold.state", bus.state, 2);
`endif

        run_div("zero_div", 8'd13, 8'd0, 8'd255, 8'd13, 1'b1, 1);

        // Restart: three iterations of 255/16, then a new start on the 4th edge.
        pulse_start(8'd255, 8'd16);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("restart.no_done", bus.done, 0);
            chk("restart.prev_q", bus.quotient, 255);
        end
        run_div("restart_9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 8);

        // start held for three edges keeps reloading.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'd100;
        bus.B     = 8'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("held.busy", bus.busy, 1);
            chk("held.done", bus.done, 0);
        end
        bus.start = 1'b0;
        wait_done(lat);
        chk("held.latency", lat, 8);
        chk("held.quotient", bus.quotient, 14);
        chk("held.remainder", bus.remainder, 2);

`ifdef DIV8_SIGNED_EN
        run_div("s_m7_2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 8);
        run_div("s_7_m2", 8'd7, 8'hFE, 8'hFD, 8'd1, 1'b0, 8);
        run_div("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, 8);
        run_div("s_m13_0", 8'hF3, 8'd0, 8'hFF, 8'hF3, 1'b1, 1);
`else
        run_div("u0_5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 8);
        run_div("u5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 8);
        run_div("u255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
        run_div("u255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 8);
`endif

        // Asynchronous reset in the middle of a cycle during an operation.
        pulse_start(8'd100, 8'd3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst.quotient", bus.quotient, 0);
        chk("async_rst.remainder", bus.remainder, 0);
        chk("async_rst.busy", bus.busy, 0);
        chk("async_rst.done", bus.done, 0);
        chk("async_rst.dbz", bus.div_by_zero, 0);
        chk("async_rst.state", bus.state, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst.done", bus.done, 0);
        chk("post_rst.state", bus.state, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
